// File: rtl/d_debounce_pkg.sv
// d_debounce_pkg: shared types and constants for the d_debounce input conditioner.
//   state_t         - FSM state encoding (IDLE: din_s matches q, CHK: candidate under test)
//   GLITCH_CNT_W    - width of the optional rejected-transition counter
//   GLITCH_CNT_MAX  - saturation value of that counter
//   sat_inc_glitch  - saturating increment helper for the glitch counter
package d_debounce_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CHK  = 1'b1
  } state_t;

  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

  // Increment that sticks at GLITCH_CNT_MAX instead of wrapping.
  function automatic logic [GLITCH_CNT_W-1:0] sat_inc_glitch(
    input logic [GLITCH_CNT_W-1:0] v
  );
    if (v == GLITCH_CNT_MAX) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/d_debounce_sync.sv
// sync_ff: plain flop chain that brings an asynchronous level into the clk domain.
// Ports:
//   clk_i  - sampling clock (rising edge)
//   rst_i  - asynchronous active-high reset, clears every stage to 0
//   d_i    - raw asynchronous level
//   q_o    - output of the last stage
// Parameter SYNC_STAGES (2..4) sets the chain depth. No logic sits between stages.
module sync_ff
  import d_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the chain, stage 0 first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/d_debounce.sv
// d_debounce: synchronizes and debounces a raw level for the d_ff data input.
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset
//   din        - raw asynchronous input level
//   q          - debounced registered level
//   rise       - one-cycle strobe in the cycle q first shows 1 after 0
//   fall       - one-cycle strobe in the cycle q first shows 0 after 1
//   glitch_cnt - saturating count of aborted candidate transitions
//                (only when D_DEBOUNCE_GLITCH_CNT_EN is defined)
// A new level is accepted after STABLE_CYCLES consecutive synchronized samples
// that differ from q. Optional feature macro: D_DEBOUNCE_GLITCH_CNT_EN.
module d_debounce
  import d_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  localparam int CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             din_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q;
  logic                    glitch_inc_s;
`endif

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (din),
    .q_o  (din_s)
  );

  // Next-state logic: the FSM only ever looks at the synchronized level.
  // With a one-bit input, "differs from q" always names the same candidate,
  // so no candidate register is kept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    glitch_inc_s = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (din_s != q_q) begin
          // This edge is the first observation of the candidate.
          state_d = CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHK: begin
        if (din_s == q_q) begin
          // Candidate vanished before enough samples: reject it.
          state_d = IDLE;
          cnt_d   = '0;
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
          glitch_inc_s = 1'b1;
`endif
        end else if (cnt_q == CNT_LAST) begin
          // STABLE_CYCLES-th agreeing sample: accept the new level.
          q_d     = din_s;
          rise_d  = din_s;
          fall_d  = ~din_s;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, stability counter, level and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef D_DEBOUNCE_GLITCH_CNT_EN
  // Saturating count of rejected transitions; a reset during CHK is not a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt_q <= '0;
    end else if (glitch_inc_s) begin
      glitch_cnt_q <= sat_inc_glitch(glitch_cnt_q);
    end else begin
      glitch_cnt_q <= glitch_cnt_q;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_d_debounce.sv
// tb_d_debounce: randomized + directed bench for d_debounce.
// Two instances share din/rst: dut_a (defaults 2/4) and dut_b (SYNC_STAGES=3,
// STABLE_CYCLES=2). A run-length reference model predicts q, strobe events and
// the glitch count; a negedge monitor pops expected strobes when the DUT shows one.
module tb_d_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b1;
  logic q_a, rise_a, fall_a;
  logic q_b, rise_b, fall_b;
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gc_a, gc_b;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    int unsigned cyc;
    bit          is_rise;
  } ev_t;

  ev_t evq_a[$];
  ev_t evq_b[$];

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int sync_n[2] = '{2, 3};
  int stab_n[2] = '{4, 2};
  bit din_log[$];
  bit m_q[2];
  int m_run[2];
  int m_gc[2];

  d_debounce dut_a (
    .clk(clk), .rst(rst), .din(din), .q(q_a), .rise(rise_a), .fall(fall_a)
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(gc_a)
`endif
  );

  d_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .din(din), .q(q_b), .rise(rise_b), .fall(fall_b)
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(gc_b)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic model_reset();
    din_log.delete();
    for (int i = 0; i < 2; i++) begin
      m_q[i]   = 1'b0;
      m_run[i] = 0;
      m_gc[i]  = 0;
    end
  endtask

  // Called just after each rising edge: the FSM of instance i sees the din
  // value sampled sync_n[i] edges earlier (0 before that history exists).
  task automatic model_update();
    int idx;
    bit obs;
    ev_t ev;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      din_log.push_back(din);
      for (int i = 0; i < 2; i++) begin
        idx = din_log.size() - 1 - sync_n[i];
        obs = (idx >= 0) ? din_log[idx] : 1'b0;
        if (obs != m_q[i]) begin
          m_run[i]++;
          if (m_run[i] == stab_n[i]) begin
            m_q[i]     = obs;
            m_run[i]   = 0;
            ev.cyc     = cyc;
            ev.is_rise = obs;
            if (i == 0) evq_a.push_back(ev);
            else        evq_b.push_back(ev);
          end
        end else begin
          if (m_run[i] > 0 && m_gc[i] < 255) m_gc[i]++;
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input bit d);
    din = d;
    @(posedge clk);
    #1;
    model_update();
  endtask

  // Drive d and measure how many edges until the requested strobe on each DUT.
  task automatic measure(input bit d, input bit want_rise, input int exp_a, input int exp_b,
                         input string name);
    int lat_a, lat_b;
    lat_a = -1;
    lat_b = -1;
    for (int k = 1; k <= 14; k++) begin
      step(d);
      if (lat_a < 0 && (want_rise ? rise_a : fall_a)) lat_a = k;
      if (lat_b < 0 && (want_rise ? rise_b : fall_b)) lat_b = k;
    end
    chk({name, "_lat_a"}, lat_a, exp_a);
    chk({name, "_lat_b"}, lat_b, exp_b);
  endtask

  // Monitor: compare level every cycle; pop an expected event whenever a strobe shows.
  always @(negedge clk) begin
    ev_t e;
    chk("q_a", {31'd0, q_a}, {31'd0, m_q[0]});
    chk("q_b", {31'd0, q_b}, {31'd0, m_q[1]});
    if (rise_a && fall_a) chk("strobe_excl_a", 32'd1, 32'd0);
    if (rise_b && fall_b) chk("strobe_excl_b", 32'd1, 32'd0);
    if (rise_a || fall_a) begin
      if (evq_a.size() == 0) begin
        chk("unexpected_strobe_a", 32'd1, 32'd0);
      end else begin
        e = evq_a.pop_front();
        chk("strobe_cyc_a", cyc, e.cyc);
        chk("strobe_rise_a", {31'd0, rise_a}, {31'd0, e.is_rise});
      end
    end
    if (rise_b || fall_b) begin
      if (evq_b.size() == 0) begin
        chk("unexpected_strobe_b", 32'd1, 32'd0);
      end else begin
        e = evq_b.pop_front();
        chk("strobe_cyc_b", cyc, e.cyc);
        chk("strobe_rise_b", {31'd0, rise_b}, {31'd0, e.is_rise});
      end
    end
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    chk("gc_a", {24'd0, gc_a}, m_gc[0]);
    chk("gc_b", {24'd0, gc_b}, m_gc[1]);
`endif
  end

  initial begin
    bit d;
    int len;
    model_reset();

    // Reset held with din=1.
    for (int k = 0; k < 3; k++) step(1'b1);
    chk("rst_q", {31'd0, q_a}, 32'd0);
    chk("rst_rise", {31'd0, rise_a}, 32'd0);
    chk("rst_fall", {31'd0, fall_a}, 32'd0);
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    chk("rst_gc", {24'd0, gc_a}, 32'd0);
`endif

    // Release with din low, settle, then clean step.
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step(1'b0);
    measure(1'b1, 1'b1, 6, 5, "clean_rise");

    // Clean fall (sweep instance gives fall on the 5th edge).
    measure(1'b0, 1'b0, 6, 5, "clean_fall");

    // Short pulse: 3 periods high is rejected by dut_a.
    for (int k = 0; k < 3; k++) step(1'b1);
    for (int k = 0; k < 8; k++) step(1'b0);
    chk("pulse_q_a", {31'd0, q_a}, 32'd0);

    // Bounce burst 1,0,1,0 then hold 1.
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    measure(1'b1, 1'b1, 6, 5, "bounce_rise");
    for (int k = 0; k < 4; k++) step(1'b0);
    for (int k = 0; k < 10; k++) step(1'b0);

    // Reset during CHK: pending transition discarded, not a glitch.
    for (int k = 0; k < 4; k++) step(1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_q", {31'd0, q_a}, 32'd0);
    chk("midrst_cnt", {29'd0, dut_a.cnt_q}, 32'd0);
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    chk("midrst_gc", {24'd0, gc_a}, 32'd0);
`endif
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    measure(1'b1, 1'b1, 6, 5, "post_rst_rise");

    // One-period low pulse rejected by the sweep instance.
    step(1'b0);
    for (int k = 0; k < 10; k++) step(1'b1);
    chk("lowpulse_q_b", {31'd0, q_b}, 32'd1);

    // Randomized hold lengths with occasional reset.
    for (int r = 0; r < 200; r++) begin
      d = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        model_reset();
        step(d);
        step(d);
        rst = 1'b0;
      end
      for (int k = 0; k < len; k++) step(d);
    end

    // Saturation: toggle every cycle from q=0 to pile up glitches.
    for (int k = 0; k < 10; k++) step(1'b0);
    rst = 1'b1;
    model_reset();
    step(1'b0);
    rst = 1'b0;
    for (int k = 0; k < 700; k++) step(k[0]);
    for (int k = 0; k < 6; k++) step(1'b0);
`ifdef D_DEBOUNCE_GLITCH_CNT_EN
    chk("sat_gc_a", {24'd0, gc_a}, 32'd255);
    chk("sat_gc_b", {24'd0, gc_b}, 32'd255);
`endif

    @(negedge clk);
    chk("pending_events_a", evq_a.size(), 32'd0);
    chk("pending_events_b", evq_b.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
